// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order imem requests, prefetch FIFO to decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
//
// state   | meaning
// S_RUN   | fetching and delivering instructions to decode
// S_HALTED| HALT accepted; no requests, in-flight responses drained and discarded
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, target_pc;
  logic [CW-1:0]     pending, pending_nx, drop, drop_nx, cnt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW:0]       occupancy;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic              rsp, redir, acc, pop, push, halt_pop, flush;
  logic              unused_lo;

  assign unused_lo = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign instr_valid = (cnt != '0);
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign imem_addr   = fetch_pc;
  assign halted      = (state == S_HALTED);

  always_comb begin
    state_nx   = state;
    rsp        = imem_rvalid && (pending != '0);
    redir      = redirect_valid && (state == S_RUN);
    occupancy  = {1'b0, cnt} + {1'b0, pending};
    imem_req   = !reset && (state == S_RUN) && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    acc        = imem_req && imem_ready;
    pop        = instr_valid && instr_ready;
    halt_pop   = pop && (state == S_RUN) && !redir && (fifo_data[rd_ptr][6:0] == 7'h7F);
    flush      = redir || halt_pop;
    push       = rsp && (drop == '0) && (state == S_RUN) && !flush;
    pending_nx = pending + CW'(acc) - CW'(rsp);
    drop_nx    = drop;
    // On a flush every response still outstanding after this cycle becomes a discard.
    if (flush)
      drop_nx = pending_nx;
    else if (rsp && (drop != '0))
      drop_nx = drop - CW'(1);
    if ((state == S_RUN) && halt_pop)
      state_nx = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      pending  <= '0;
      drop     <= '0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      drop    <= drop_nx;
      if (redir) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (acc)  fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push) resp_pc  <= resp_pc + ADDR_W'(4);
      end
      if (flush) begin
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if ((state == S_RUN) && instr_valid && !instr_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side memory plus a queue/epoch reference model.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ready, imem_rvalid, instr_valid, instr_ready;
  logic        redirect_valid, halted;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] ep; } req_t;

  ent_t        fq[$];      // words decode should see, in order
  req_t        mq[$];      // requests accepted by memory, not yet answered
  logic [31:0] m_fpc, m_ep, halt_addr;
  logic        m_run, m_valid;
  int          errors = 0, checks = 0;
  int unsigned m_pops;
  logic        done;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == halt_addr) return 32'h0000_007F;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[6:0] == 7'h7F) w[0] = 1'b0;
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model.
  task automatic step(input logic rst_i, input logic rdy_i, input logic rv_i,
                      input logic irdy_i, input logic red_i, input logic [31:0] rpc_i);
    logic req_e, rsp, pop, hlt, acc, kept, redm;
    req_t r;
    @(negedge clk);
    reset          = rst_i;
    imem_ready     = rdy_i;
    imem_rvalid    = rv_i;
    instr_ready    = irdy_i;
    redirect_valid = red_i;
    redirect_pc    = rpc_i;
    imem_rdata     = (mq.size() > 0) ? mem_word(mq[0].addr) : $urandom;
    #1;
    if (rst_i) begin
      check_eq("req_in_reset", 64'(imem_req), 64'(0));
      fq.delete(); mq.delete();
      m_fpc = RESET_PC; m_run = 1'b1; m_ep++; m_pops = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    req_e = m_run && !red_i && ((fq.size() + mq.size()) < DEPTH);
    check_eq("imem_req", 64'(imem_req), 64'(req_e));
    check_eq("imem_addr", 64'(imem_addr), 64'(m_fpc));
    check_eq("instr_valid", 64'(instr_valid), 64'(fq.size() > 0));
    if (fq.size() > 0) begin
      check_eq("instr", 64'(instr), 64'(fq[0].data));
      check_eq("instr_pc", 64'(instr_pc), 64'(fq[0].pc));
    end
    check_eq("halted", 64'(halted), 64'(!m_run));
    rsp  = rv_i && (mq.size() > 0);
    pop  = (fq.size() > 0) && irdy_i;
    redm = red_i && m_run;
    hlt  = m_run && !redm && pop && (fq[0].data[6:0] == 7'h7F);
    acc  = req_e && rdy_i;
    kept = 1'b0;
    r    = '0;
    if (rsp) begin
      r    = mq.pop_front();
      kept = m_run && !redm && !hlt && (r.ep == m_ep);
    end
    if (pop) m_pops++;
    if (redm) begin
      fq.delete(); m_ep++; m_fpc = {rpc_i[31:2], 2'b00};
    end else if (hlt) begin
      fq.delete(); m_ep++; m_run = 1'b0;
    end else begin
      if (pop) void'(fq.pop_front());
      if (kept) fq.push_back('{pc: r.addr, data: mem_word(r.addr)});
    end
    if (acc) begin
      mq.push_back('{addr: m_fpc, ep: m_ep});
      m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic run_auto(input int n, input logic irdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, mq.size() > 0, irdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_valid = 1'b0; m_ep = 0; m_run = 1'b1; m_fpc = RESET_PC; m_pops = 0;
    halt_addr = 32'h1;
    do_reset(3);

    // sequential streaming, 1-cycle memory
    run_auto(20, 1'b1);

    // decode stalls: FIFO fills, requests stop, head held
    run_auto(10, 1'b0);
    check_eq("full_no_req", 64'(imem_req), 64'(0));
    run_auto(20, 1'b1);

    // redirect with 2 in flight and 2 buffered
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (fq.size() == 2 && mq.size() == 2) done = 1'b1;
      else step(1'b0, 1'b1, (mq.size() > 0) && (fq.size() < 2), fq.size() > 2, 1'b0, 32'h0);
    end
    check_eq("redir_setup", 64'(done), 64'(1));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
    run_auto(15, 1'b1);

    // HALT at 0x20
    halt_addr = 32'h20;
    step(1'b0, 1'b1, mq.size() > 0, 1'b1, 1'b1, 32'h10);
    run_auto(30, 1'b1);
    check_eq("halt_sticky", 64'(halted), 64'(1));
    step(1'b0, 1'b1, mq.size() > 0, 1'b1, 1'b1, 32'h300);
    run_auto(5, 1'b1);

    // redirect in the same cycle as a HALT pop
    do_reset(2);
    halt_addr = 32'h40;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (fq.size() > 0 && fq[0].pc == 32'h40) begin
        step(1'b0, 1'b1, mq.size() > 0, 1'b1, 1'b1, 32'h200);
        done = 1'b1;
      end else run_auto(1, 1'b1);
    end
    check_eq("halt_redir_seen", 64'(done), 64'(1));
    halt_addr = 32'h1;
    run_auto(20, 1'b1);
    check_eq("no_halt", 64'(halted), 64'(0));

    // reset with requests in flight, then stale responses
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mq.size() == 2) done = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    check_eq("pending_setup", 64'(done), 64'(1));
    do_reset(2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    run_auto(20, 1'b1);

    // PC wrap at top of address space, misaligned target
    step(1'b0, 1'b1, mq.size() > 0, 1'b1, 1'b1, 32'hFFFF_FFFA);
    run_auto(15, 1'b1);

`ifdef FETCH_PERF_EN
    check_eq("perf_fetched", 64'(perf_fetched), 64'(m_pops));
`endif

    // randomized traffic
    halt_addr = 32'h120;
    for (int i = 0; i < 3000; i++) begin
      if ((!m_run && ($urandom % 8 == 0)) || ($urandom % 500 == 0))
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      else
        step(1'b0, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
             ($urandom % 30) == 0, $urandom % 1024);
    end

`ifdef FETCH_PERF_EN
    @(negedge clk); #1;
    check_eq("perf_fetched_end", 64'(perf_fetched), 64'(m_pops));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
